// File: rtl/clock_monitor_if.sv
// Port bundle for the clock monitor: the monitored slow clock in,
// measurement and lock status out.
interface clock_monitor_if #(
    parameter int CNT_W = 32
);
    logic             sig_in;
    logic             meas_valid;
    logic [CNT_W-1:0] meas_val;
    logic             meas_level;
    logic             locked;
    logic             fault;
    logic             timeout;
    logic [15:0]      err_cnt;

    modport master (
        output sig_in,
        input  meas_valid,
        input  meas_val,
        input  meas_level,
        input  locked,
        input  fault,
        input  timeout,
        input  err_cnt
    );

    modport slave (
        input  sig_in,
        output meas_valid,
        output meas_val,
        output meas_level,
        output locked,
        output fault,
        output timeout,
        output err_cnt
    );
endinterface

// File: rtl/clock_monitor.sv
// Measures each half-period of a slow asynchronous clock and tracks
// lock/fault/timeout status against a nominal half-period.
module clock_monitor #(
    parameter int HALF_NOM   = 200000,
    parameter int TOL        = 2,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 400000,
    parameter int CNT_W      = 32
) (
    input  logic           clk_40MHz,
    input  logic           rst,
    clock_monitor_if.slave mon
);
    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        LOCKED,
        FAULT
    } state_t;

    localparam int GW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);

    // Tolerance window is evaluated one bit wider so HALF_NOM+TOL cannot wrap.
    localparam longint LO_L = (HALF_NOM > TOL) ?
                              longint'(HALF_NOM - TOL) : longint'(0);
    localparam longint HI_L = longint'(HALF_NOM) + longint'(TOL);

    localparam logic [CNT_W:0]   LO   = (CNT_W + 1)'(LO_L);
    localparam logic [CNT_W:0]   HI   = (CNT_W + 1)'(HI_L);
    localparam logic [CNT_W-1:0] TO_V = CNT_W'(TIMEOUT);
    localparam logic [GW-1:0]    LAST = GW'(LOCK_COUNT - 1);

    logic             s1;
    logic             s2;
    logic             s3;
    logic             rise;
    logic             fall;
    logic             edge_seen;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W:0]   cnt_x;
    logic             good;
    logic             tmo_hit;

    state_t           state;
    state_t           state_n;
    logic [GW-1:0]    gcnt;
    logic [GW-1:0]    gcnt_n;
    logic             err_inc;
    logic             mv_n;
    logic             tmo_n;

    logic             meas_valid_q;
    logic [CNT_W-1:0] meas_val_q;
    logic             meas_level_q;
    logic             locked_q;
    logic             fault_q;
    logic             tmo_q;
    logic [15:0]      err_q;

    assign rise      = s2 & ~s3;
    assign fall      = ~s2 & s3;
    assign edge_seen = rise | fall;

    assign cnt_x   = {1'b0, cnt};
    assign good    = (cnt_x >= LO) && (cnt_x <= HI);
    assign tmo_hit = (state != IDLE) && !edge_seen && (cnt == TO_V);

    always_comb begin
        cnt_n = cnt;
        if (edge_seen) begin
            cnt_n = CNT_W'(1);
        end else if (cnt != '1) begin
            cnt_n = cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_n = state;
        gcnt_n  = gcnt;
        err_inc = 1'b0;
        mv_n    = 1'b0;
        tmo_n   = 1'b0;
        // tmo_hit already excludes edge cycles, so an edge always wins.
        unique case (1'b1)
            edge_seen: begin
                mv_n = (state != IDLE);
                unique case (state)
                    IDLE: begin
                        state_n = ACQUIRE;
                        gcnt_n  = '0;
                    end
                    ACQUIRE: begin
                        if (!good) begin
                            gcnt_n = '0;
                        end else if (gcnt >= LAST) begin
                            state_n = LOCKED;
                            gcnt_n  = '0;
                        end else begin
                            gcnt_n = gcnt + GW'(1);
                        end
                    end
                    LOCKED: begin
                        if (!good) begin
                            state_n = FAULT;
                            err_inc = 1'b1;
                        end
                    end
                    FAULT: begin
                        if (good) begin
                            state_n = ACQUIRE;
                            gcnt_n  = GW'(1);
                        end
                    end
                    default: state_n = IDLE;
                endcase
            end
            tmo_hit: begin
                state_n = IDLE;
                gcnt_n  = '0;
                tmo_n   = 1'b1;
                err_inc = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_40MHz or posedge rst) begin
        if (rst) begin
            s1           <= 1'b0;
            s2           <= 1'b0;
            s3           <= 1'b0;
            cnt          <= '0;
            state        <= IDLE;
            gcnt         <= '0;
            meas_valid_q <= 1'b0;
            meas_val_q   <= '0;
            meas_level_q <= 1'b0;
            locked_q     <= 1'b0;
            fault_q      <= 1'b0;
            tmo_q        <= 1'b0;
            err_q        <= '0;
        end else begin
            s1           <= mon.sig_in;
            s2           <= s1;
            s3           <= s2;
            cnt          <= cnt_n;
            state        <= state_n;
            gcnt         <= gcnt_n;
            meas_valid_q <= mv_n;
            if (mv_n) begin
                meas_val_q   <= cnt;
                meas_level_q <= fall;
            end
            locked_q <= (state_n == LOCKED);
            fault_q  <= (state_n == FAULT);
            tmo_q    <= tmo_n;
            if (err_inc && (err_q != 16'hFFFF)) begin
                err_q <= err_q + 16'd1;
            end
        end
    end

    assign mon.meas_valid = meas_valid_q;
    assign mon.meas_val   = meas_val_q;
    assign mon.meas_level = meas_level_q;
    assign mon.locked     = locked_q;
    assign mon.fault      = fault_q;
    assign mon.timeout    = tmo_q;
    assign mon.err_cnt    = err_q;
endmodule

// File: tb/tb_clock_monitor.sv
// Randomised half-period stimulus for clock_monitor, checked by a
// queue-based scoreboard fed from an event-level reference model.
module tb_clock_monitor;
    localparam int HN  = 10;
    localparam int TL  = 1;
    localparam int LC  = 4;
    localparam int TO  = 20;
    localparam int CW  = 32;
    localparam int LAT = 3;

    typedef struct {
        bit tmo;
        int val;
        bit lvl;
        bit lk;
        bit flt;
        int err;
        int t;
    } ev_t;

    logic clk_40MHz = 1'b0;
    logic rst       = 1'b1;
    int   cyc       = 0;
    int   n_cmp     = 0;
    int   n_bad     = 0;

    ev_t  q[$];
    bit   armed = 0;
    bit   lk    = 0;
    bit   flt   = 0;
    int   run   = 0;
    int   err   = 0;
    int   t_prev = 0;

    clock_monitor_if #(.CNT_W(CW)) mif();

    clock_monitor #(
        .HALF_NOM  (HN),
        .TOL       (TL),
        .LOCK_COUNT(LC),
        .TIMEOUT   (TO),
        .CNT_W     (CW)
    ) dut (
        .clk_40MHz(clk_40MHz),
        .rst      (rst),
        .mon      (mif.slave)
    );

    always #5 clk_40MHz = ~clk_40MHz;

    always @(posedge clk_40MHz) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0d required=%0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bump_err();
        if (err < 65535) err++;
    endtask

    // Reference: each half is judged by its length alone; an armed
    // monitor that sees a half longer than TO reports a timeout and the
    // edge that finally ends it only re-arms.
    task automatic model_half(input int len, input bit lvl, input int t0);
        ev_t e;
        bit  ok;
        if (!armed) begin
            armed = 1; run = 0; lk = 0; flt = 0;
            return;
        end
        if (len > TO) begin
            bump_err();
            lk = 0; flt = 0; run = 0;
            e = '{tmo: 1'b1, val: 0, lvl: 1'b0, lk: 1'b0, flt: 1'b0,
                  err: err, t: t0 + TO + LAT};
            q.push_back(e);
            return;
        end
        ok = (len >= HN - TL) && (len <= HN + TL);
        if (lk) begin
            if (!ok) begin
                lk = 0; flt = 1;
                bump_err();
            end
        end else if (flt) begin
            if (ok) begin
                flt = 0; run = 1;
            end
        end else begin
            run = ok ? run + 1 : 0;
            if (run >= LC) begin
                lk = 1; run = 0;
            end
        end
        e = '{tmo: 1'b0, val: len, lvl: lvl, lk: lk, flt: flt,
              err: err, t: t0 + len + LAT};
        q.push_back(e);
    endtask

    task automatic drive_half(input int len);
        model_half(len, mif.sig_in, t_prev);
        repeat (len) @(posedge clk_40MHz);
        #1;
        mif.sig_in = ~mif.sig_in;
        t_prev = cyc;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_meas_valid"}, mif.meas_valid, 0);
        chk({tag, "_meas_val"}, mif.meas_val, 0);
        chk({tag, "_meas_level"}, mif.meas_level, 0);
        chk({tag, "_locked"}, mif.locked, 0);
        chk({tag, "_fault"}, mif.fault, 0);
        chk({tag, "_timeout"}, mif.timeout, 0);
        chk({tag, "_err_cnt"}, mif.err_cnt, 0);
    endtask

    task automatic do_reset();
        repeat (LAT + 2) @(posedge clk_40MHz);
        #1;
        rst = 1'b1;
        mif.sig_in = 1'b0;
        #2;
        check_zero("mid_reset");
        @(posedge clk_40MHz);
        #1;
        check_zero("held_reset");
        rst = 1'b0;
        armed = 0; lk = 0; flt = 0; run = 0; err = 0;
    endtask

    initial begin
        ev_t e;
        forever begin
            @(posedge clk_40MHz);
            #1;
            if (mif.meas_valid || mif.timeout) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_event: actual valid=%0b timeout=%0b required none (cyc %0d)",
                             mif.meas_valid, mif.timeout, cyc);
                end else begin
                    e = q.pop_front();
                    chk("timeout", mif.timeout, e.tmo);
                    chk("meas_valid", mif.meas_valid, longint'(!e.tmo));
                    chk("event_cycle", cyc, e.t);
                    if (!e.tmo) begin
                        chk("meas_val", mif.meas_val, e.val);
                        chk("meas_level", mif.meas_level, e.lvl);
                    end
                    chk("locked", mif.locked, e.lk);
                    chk("fault", mif.fault, e.flt);
                    chk("err_cnt", mif.err_cnt, e.err);
                end
            end
        end
    end

    initial begin
        int r;
        int len;
        mif.sig_in = 1'b0;
        rst = 1'b1;
        #2;
        check_zero("por");
        repeat (2) @(posedge clk_40MHz);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // lock on a clean square wave
        drive_half(7);
        repeat (6) drive_half(10);
        // jitter inside tolerance
        repeat (4) begin
            drive_half(9);
            drive_half(11);
        end
        // one long half, then recover
        drive_half(13);
        repeat (4) drive_half(10);
        // edge landing exactly on the timeout count
        drive_half(20);
        repeat (5) drive_half(10);
        // signal stalls past the timeout
        drive_half(30);
        repeat (6) drive_half(10);
        // reset while locked, then re-lock
        do_reset();
        repeat (6) drive_half(10);

        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(99));
            if (r < 80)      len = 9 + int'($urandom_range(2));
            else if (r < 86) len = 12 + int'($urandom_range(7));
            else if (r < 91) len = 3 + int'($urandom_range(5));
            else if (r < 95) len = 20;
            else             len = 21 + int'($urandom_range(14));
            drive_half(len);
            if ($urandom_range(99) == 0) do_reset();
        end

        repeat (LAT + 3) @(posedge clk_40MHz);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/clock_monitor.md
CLOCK_MONITOR -- requirements
Module: clock_monitor

Interface
REQ-001 Parameter HALF_NOM, default 200000, nominal half-period of the monitored signal in clk_40MHz cycles (100 Hz).
REQ-002 Parameter TOL, default 2, allowed deviation from HALF_NOM in cycles, inclusive.
REQ-003 Parameter LOCK_COUNT, default 4, consecutive in-tolerance half-periods required to lock.
REQ-004 Parameter TIMEOUT, default 400000, cycles without an edge before a timeout is declared.
REQ-005 Parameter CNT_W, default 32, width of the half-period counter and measurement.
REQ-006 clk_40MHz  input  1  system clock; all state advances on its rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 sig_in  input  1  monitored slow clock, asynchronous to clk_40MHz.
REQ-009 meas_valid  output  1  one-cycle pulse: a completed half-period measurement is presented.
REQ-010 meas_val  output  CNT_W  length of the last completed half-period in cycles.
REQ-011 meas_level  output  1  level of sig_in during the measured half (1 = high phase).
REQ-012 locked  output  1  high while the FSM is in LOCKED.
REQ-013 fault  output  1  high while the FSM is in FAULT.
REQ-014 timeout  output  1  one-cycle pulse on timeout.
REQ-015 err_cnt  output  16  saturating count of LOCKED->FAULT transitions plus timeouts.

Function
REQ-016 sig_in SHALL pass through a 2-FF synchronizer followed by a third FF; rise = s2 & ~s3, fall = ~s2 & s3.
REQ-017 Half counter SHALL increment each cycle and saturate at all-ones; on an edge cycle it SHALL load 1.
REQ-018 On an edge, the counter value before reload SHALL be the measurement, so a half of N cycles measures exactly N.
REQ-019 The first edge after reset or after a timeout SHALL only arm measurement; it produces no meas_valid.
REQ-020 Each subsequent edge SHALL register meas_valid=1, meas_val, and meas_level (1 on fall, 0 on rise), visible the following cycle.
REQ-021 A measurement is good iff HALF_NOM-TOL <= meas <= HALF_NOM+TOL, unsigned compare, no wrap.
REQ-022 FSM states: IDLE, ACQUIRE, LOCKED, FAULT; good_cnt tracks consecutive good measurements.
REQ-023 IDLE -> ACQUIRE on the arming edge, good_cnt=0.
REQ-024 ACQUIRE: good measurement increments good_cnt; reaching LOCK_COUNT -> LOCKED; bad measurement clears good_cnt and stays.
REQ-025 LOCKED: bad measurement -> FAULT and err_cnt+1; good measurement stays.
REQ-026 FAULT: good measurement -> ACQUIRE with good_cnt=1; bad measurement stays.
REQ-027 In ACQUIRE, LOCKED or FAULT, a counter value of TIMEOUT with no edge that cycle SHALL pulse timeout, enter IDLE, disarm, and increment err_cnt.
REQ-028 If an edge and the timeout condition coincide, the edge SHALL win and no timeout occurs.
REQ-029 In IDLE, the counter SHALL keep saturating; no timeout is reported.
REQ-030 err_cnt SHALL hold at 16'hFFFF; a simultaneous FAULT entry and timeout cannot occur.
REQ-031 locked, fault, meas_valid and timeout SHALL be registered outputs, updated in the same cycle as the FSM state.

Reset
REQ-032 While rst=1: all synchronizer FFs, counter, good_cnt, meas_val, meas_level and err_cnt = 0; state = IDLE; all pulses and flags = 0; disarmed.
REQ-033 Deassertion of rst SHALL take effect on the next clk_40MHz rising edge.

Verification
All scenarios use HALF_NOM=10, TOL=1, LOCK_COUNT=4, TIMEOUT=20.
REQ-034 Square wave, halves of 10 -> first edge gives no pulse; subsequent edges give meas_val=10; locked=1 alongside the 4th meas_valid.
REQ-035 Locked with halves alternating 9 and 11 -> locked stays 1; err_cnt=0.
REQ-036 Locked, then one half of 13 -> fault=1, locked=0, err_cnt=1; then 4 halves of 10 -> ACQUIRE after the 1st, locked=1 after the 4th.
REQ-037 Locked, then sig_in held constant -> timeout pulse 20 cycles after the last edge; locked=0, err_cnt+1; next edge produces no meas_valid.
REQ-038 rst pulsed while LOCKED -> all outputs 0 during reset; re-lock requires arming edge plus 4 good halves.
REQ-039 Edge arriving exactly when the counter equals 20 -> meas_valid with meas_val=20, no timeout pulse; FAULT entered if previously LOCKED.
